// File: rtl/irq_pending_capture_pkg.sv
// Shared definitions for the interrupt request-capture stage:
// request/index widths, offer FSM states and a one-hot helper.
package irq_pending_capture_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } irq_state_e;

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/irq_pending_capture_edge.sv
// Request edge detector: registers the raw request lines and produces the
// vector of new captures, with masking and edge/level selection applied.
module irq_pending_capture_edge
  import irq_pending_capture_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] new_req
);

  logic [N_REQ-1:0] req_d;
  logic [N_REQ-1:0] req_q;

  always_comb begin
    req_d   = req_in;
    new_req = (EDGE_MODE ? (req_in & ~req_q) : req_in) & ~mask;
  end

  // Loaded in reset as well, so levels held across reset never look like an edge.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

endmodule

// File: rtl/irq_pending_capture.sv
// Sticky pending register fed by the edge detector, driving an external priority
// encoder; the encoder's index is offered to a consumer over valid/ready.
module irq_pending_capture
  import irq_pending_capture_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] pend_out,
  input  logic [IDX_W-1:0] enc_idx,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ready,
  output logic             any_pend,
  output logic [CNT_W-1:0] miss_cnt
);

  logic [N_REQ-1:0] new_req;
  logic [N_REQ-1:0] clr;
  logic             acc;
  logic             collide;

  logic [N_REQ-1:0] pend_d,     pend_q;
  irq_state_e       state_d,    state_q;
  logic [IDX_W-1:0] irq_idx_d,  irq_idx_q;
  logic [CNT_W-1:0] miss_cnt_d, miss_cnt_q;

  irq_pending_capture_edge #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk     (clk),
    .req_in  (req_in),
    .mask    (mask),
    .new_req (new_req)
  );

  always_comb begin
    pend_out  = pend_q & ~mask;
    any_pend  = |pend_out;
    irq_valid = (state_q == ST_OFFER);
    irq_idx   = irq_idx_q;
    miss_cnt  = miss_cnt_q;
  end

  // A new capture on the bit being serviced this cycle re-sets it rather than colliding.
  always_comb begin
    acc     = irq_valid & irq_ready;
    clr     = acc ? idx_onehot(irq_idx_q) : '0;
    pend_d  = (pend_q & ~clr) | new_req;
    collide = |(new_req & pend_q & ~clr);

    miss_cnt_d = miss_cnt_q;
    if (collide && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // The offered index is frozen on entry to OFFER; masking never retracts it.
  always_comb begin
    state_d   = state_q;
    irq_idx_d = irq_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          irq_idx_d = enc_idx;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (irq_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      state_q    <= ST_IDLE;
      irq_idx_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      state_q    <= state_d;
      irq_idx_q  <= irq_idx_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
